// File: rtl/gate_selftest.sv
// Self-test sequencer for the two-input AND/OR/NAND gate block: sweeps all
// {A,B} vectors, waits SETTLE_CYCLES, then checks the three gate outputs.
// Ports: clk, rst_n (sync, active-low), start; A/B drive the gate block;
// AND_In/OR_In/NAND_In are its outputs. busy, done (1-cycle pulse), pass,
// and err_count (saturating) report the run. fail_valid/fail_vec/fail_got
// hold the first mismatch when GATE_SELFTEST_FAILLOG_EN is defined, and are
// tied to 0 otherwise.
`timescale 1ns/1ps
module gate_selftest #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             A,
  output logic             B,
  input  logic             AND_In,
  input  logic             OR_In,
  input  logic             NAND_In,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec,
  output logic [2:0]       fail_got
);

  localparam logic [7:0] CNT_INIT  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t           state, state_d;
  logic [1:0]       vec, vec_d;
  logic [7:0]       pidx, pidx_d;
  logic [7:0]       cnt, cnt_d;
  logic [ERR_W-1:0] err_d;
  logic             pass_d;
  logic             a_d, b_d;
  logic             clear;
  logic             miss;
  logic [2:0]       got;
  logic [2:0]       expct;

  assign got   = {AND_In, OR_In, NAND_In};
  assign expct = {A & B, A | B, ~(A & B)};
  assign miss  = (state == CHECK) && (got != expct);

  always_comb begin
    state_d = state;
    vec_d   = vec;
    pidx_d  = pidx;
    cnt_d   = cnt;
    err_d   = err_count;
    pass_d  = pass;
    a_d     = A;
    b_d     = B;
    busy    = 1'b0;
    done    = 1'b0;
    clear   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          vec_d   = 2'd0;
          pidx_d  = 8'd0;
          err_d   = '0;
          pass_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (cnt == 8'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      CHECK: begin
        busy = 1'b1;
        if (miss && (err_count != '1)) begin
          err_d = err_count + ERR_W'(1);
        end
        if ((vec == 2'd3) && (pidx == PASS_LAST)) begin
          state_d = DONE;
        end else begin
          vec_d = vec + 2'd1;
          if (vec == 2'd3) begin
            pidx_d = pidx + 8'd1;
          end
          {a_d, b_d} = vec + 2'd1;
          cnt_d      = CNT_INIT;
          state_d    = SETTLE;
        end
      end
      DONE: begin
        done    = 1'b1;
        pass_d  = (err_count == '0);
        a_d     = 1'b0;
        b_d     = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= 2'd0;
      pidx      <= 8'd0;
      cnt       <= 8'd0;
      err_count <= '0;
      pass      <= 1'b0;
      A         <= 1'b0;
      B         <= 1'b0;
    end else begin
      state     <= state_d;
      vec       <= vec_d;
      pidx      <= pidx_d;
      cnt       <= cnt_d;
      err_count <= err_d;
      pass      <= pass_d;
      A         <= a_d;
      B         <= b_d;
    end
  end

`ifdef GATE_SELFTEST_FAILLOG_EN
  // Only the first mismatch of a run is kept.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      fail_valid <= 1'b0;
      fail_vec   <= 2'd0;
      fail_got   <= 3'd0;
    end else if (miss && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_vec   <= {A, B};
      fail_got   <= got;
    end
  end
`else
  assign fail_valid = 1'b0;
  assign fail_vec   = 2'd0;
  assign fail_got   = 3'd0;
  logic unused;
  assign unused = clear;
`endif

endmodule

// File: tb/tb_gate_selftest.sv
// Bench for gate_selftest: random fault masks on a gate model, expected
// results queued per run and checked by an independent monitor.
`timescale 1ns/1ps
module tb_gate_selftest;

  localparam int S = 2;
  localparam int P = 1;
  localparam int N = 4 * P * (S + 1);

  logic       clk = 0;
  logic       rst_n = 0;
  logic       start = 0;
  logic       A, B, busy, done, pass;
  logic [7:0] err_count;
  logic       fv;
  logic [1:0] fvec;
  logic [2:0] fgot;
  logic [2:0] gates;
  logic [2:0] mask [4];

  logic       s_start = 0;
  logic       s_a, s_b, s_busy, s_done, s_pass;
  logic [1:0] s_err;
  logic       s_fv;
  logic [1:0] s_fvec;
  logic [2:0] s_fgot;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         c0;
    int         err;
    bit         pas;
    bit         fv;
    logic [1:0] fvec;
    logic [2:0] fgot;
  } exp_t;

  exp_t sb [$];
  exp_t cur, held;
  bit   pend = 0;
  bit   hit;
  int   k;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Faulty gate block: ideal outputs flipped by a per-vector mask.
  assign gates = {A & B, A | B, ~(A & B)} ^ mask[{A, B}];

  gate_selftest u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(A), .B(B),
    .AND_In(gates[2]), .OR_In(gates[1]), .NAND_In(gates[0]),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fv), .fail_vec(fvec), .fail_got(fgot)
  );

  gate_selftest #(.SETTLE_CYCLES(1), .PASSES(2), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .A(s_a), .B(s_b),
    .AND_In(~(s_a & s_b)), .OR_In(~(s_a | s_b)), .NAND_In(s_a & s_b),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
    .fail_valid(s_fv), .fail_vec(s_fvec), .fail_got(s_fgot)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] ideal(input int v);
    logic a, b;
    a = v[1];
    b = v[0];
    return {a & b, a | b, ~(a & b)};
  endfunction

  // Whole-run outcome from the mask table.
  function automatic exp_t model(input int c0, input int passes,
                                 input int ew);
    exp_t e;
    int   emax;
    logic [2:0] g;
    emax   = (1 << ew) - 1;
    e.c0   = c0;
    e.err  = 0;
    e.fv   = 0;
    e.fvec = 0;
    e.fgot = 0;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 4; v++) begin
        g = ideal(v) ^ mask[v];
        if (g != ideal(v)) begin
          if (!e.fv) begin
            e.fv   = 1;
            e.fvec = 2'(v);
            e.fgot = g;
          end
          if (e.err < emax) e.err++;
        end
      end
    end
    e.pas = (e.err == 0);
`ifndef GATE_SELFTEST_FAILLOG_EN
    e.fv   = 0;
    e.fvec = 0;
    e.fgot = 0;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      hit = 0;
      if (pend && cyc == held.c0 + N + 1) begin
        chk("pass", pass, held.pas);
        chk("fail_valid", fv, held.fv);
        chk("fail_vec", fvec, held.fvec);
        chk("fail_got", fgot, held.fgot);
        pend = 0;
      end
      if (sb.size() > 0) begin
        cur = sb[0];
        k   = cyc - cur.c0;
        if (k >= 0 && k < N) begin
          chk("busy", busy, 1);
          chk("vec", {A, B}, (k / (S + 1)) % 4);
        end else if (k == N) begin
          hit = 1;
          chk("done_edge", done, 1);
          chk("busy_done", busy, 0);
          chk("err_count", err_count, cur.err);
          held = cur;
          pend = 1;
          void'(sb.pop_front());
        end
      end
      if (!hit) chk("done_low", done, 0);
    end
  end

  task automatic wait_idle();
    for (int w = 0; w < 60 && (sb.size() != 0 || pend); w++)
      @(posedge clk);
    #1;
    if (sb.size() != 0 || pend) begin
      total++;
      bad++;
      $display("FAIL timeout got=%0d pending exp=0", sb.size());
      sb.delete();
      pend = 0;
    end
  endtask

  task automatic set_mask(input logic [2:0] m0, input logic [2:0] m1,
                          input logic [2:0] m2, input logic [2:0] m3);
    mask[0] = m0;
    mask[1] = m1;
    mask[2] = m2;
    mask[3] = m3;
  endtask

  task automatic run(input bit noise);
    int c0;
    start = 1;
    c0 = cyc + 1;
    sb.push_back(model(c0, P, 8));
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      start = noise ? 1'($urandom % 2) : 1'b0;
      @(posedge clk); #1;
    end
    start = 0;
    wait_idle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_A"}, A, 0);
    chk({tag, "_B"}, B, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_fv"}, fv, 0);
    chk({tag, "_fvec"}, fvec, 0);
    chk({tag, "_fgot"}, fgot, 0);
  endtask

  initial begin
    int c0;
    set_mask(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    run(0);
    set_mask(0, 0, 0, 3'b100);
    run(0);
    set_mask(3'b111, 3'b111, 3'b111, 3'b111);
    run(0);
    set_mask(0, 3'b010, 0, 0);
    run(1);

    // start held high: second run accepted on the IDLE cycle after DONE
    set_mask(0, 3'b001, 0, 0);
    start = 1;
    c0 = cyc + 1;
    sb.push_back(model(c0, P, 8));
    sb.push_back(model(c0 + N + 2, P, 8));
    repeat (N + 3) @(posedge clk);
    #1;
    start = 0;
    wait_idle();

    // reset in the middle of a run
    set_mask(3'b100, 0, 0, 0);
    start = 1;
    sb.push_back(model(cyc + 1, P, 8));
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 0;
    sb.delete();
    pend = 0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1;
    set_mask(0, 0, 0, 0);
    run(0);

    for (int r = 0; r < 20; r++) begin
      for (int v = 0; v < 4; v++)
        mask[v] = ($urandom % 3 == 0) ? 3'($urandom % 8) : 3'd0;
      if (r % 5 == 0) set_mask(0, 0, 0, 0);
      run(1'($urandom % 2));
    end

    // saturating counter instance: 8 mismatches into a 2-bit counter
    s_start = 1;
    c0 = cyc + 1;
    @(posedge clk); #1;
    s_start = 0;
    for (int w = 0; w < 60 && !s_done; w++) @(negedge clk);
    chk("sat_done_edge", cyc, c0 + 16);
    chk("sat_err", s_err, 3);
    @(negedge clk);
    chk("sat_pass", s_pass, 0);
`ifdef GATE_SELFTEST_FAILLOG_EN
    chk("sat_fv", s_fv, 1);
    chk("sat_fvec", s_fvec, 0);
    chk("sat_fgot", s_fgot, 3'b110);
`else
    chk("sat_fv", s_fv, 0);
    chk("sat_fgot", s_fgot, 0);
`endif
    chk("sat_idle_busy", s_busy, 0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
